// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the 16-bit CPU control path: opcodes, function selects,
// PC controls, sequencer states and decoded instruction classes.
package cpu_ctrl_pkg;

    localparam logic [6:0] OP_MOVA = 7'b0000000;
    localparam logic [6:0] OP_ADD  = 7'b0000010;
    localparam logic [6:0] OP_SUB  = 7'b0000101;
    localparam logic [6:0] OP_AND  = 7'b0001000;
    localparam logic [6:0] OP_ADI  = 7'b1000010;
    localparam logic [6:0] OP_LD   = 7'b0010000;
    localparam logic [6:0] OP_ST   = 7'b0100000;
    localparam logic [6:0] OP_BRZ  = 7'b1100000;
    localparam logic [6:0] OP_JMP  = 7'b1110000;
    localparam logic [6:0] OP_LRI  = 7'b0010001;
    localparam logic [6:0] OP_SRM  = 7'b0001101;

    localparam logic [3:0] FS_MOVA = 4'b0000;
    localparam logic [3:0] FS_ADD  = 4'b0010;
    localparam logic [3:0] FS_SUB  = 4'b0101;
    localparam logic [3:0] FS_AND  = 4'b1000;
    localparam logic [3:0] FS_SHR  = 4'b1101;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    localparam logic [3:0] TMP_R8 = 4'b1000;

    typedef enum logic [1:0] {
        INF = 2'b00,
        EX0 = 2'b01,
        EX1 = 2'b10,
        EX2 = 2'b11
    } state_t;

    // Bit positions within the one-hot instruction class vector.
    localparam int CLS_ALU = 0;
    localparam int CLS_ADI = 1;
    localparam int CLS_LD  = 2;
    localparam int CLS_ST  = 3;
    localparam int CLS_BRZ = 4;
    localparam int CLS_JMP = 5;
    localparam int CLS_LRI = 6;
    localparam int CLS_SRM = 7;
    localparam int CLS_NOP = 8;
    localparam int CLS_W   = 9;

    function automatic logic [3:0] alu_fs(input logic [6:0] opcode);
        logic [3:0] fs;
        case (opcode)
            OP_ADD:  fs = FS_ADD;
            OP_SUB:  fs = FS_SUB;
            OP_AND:  fs = FS_AND;
            default: fs = FS_MOVA;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Maps the 7-bit opcode field onto a one-hot instruction class; anything
// unrecognised falls into the NOP class.
module opcode_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0]       opcode,
    output logic [CLS_W-1:0] cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_MOVA, OP_ADD, OP_SUB, OP_AND: cls[CLS_ALU] = 1'b1;
            OP_ADI:  cls[CLS_ADI] = 1'b1;
            OP_LD:   cls[CLS_LD]  = 1'b1;
            OP_ST:   cls[CLS_ST]  = 1'b1;
            OP_BRZ:  cls[CLS_BRZ] = 1'b1;
            OP_JMP:  cls[CLS_JMP] = 1'b1;
            OP_LRI:  cls[CLS_LRI] = 1'b1;
            OP_SRM:  cls[CLS_SRM] = 1'b1;
            default: cls[CLS_NOP] = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer: drives the full control word each cycle from the
// registered state, shift counter and instruction register.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        V,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic [3:0]  DA,
    output logic [3:0]  AA,
    output logic [3:0]  BA,
    output logic [3:0]  FS,
    output logic        RW,
    output logic        MB,
    output logic        MD,
    output logic        MM,
    output logic        MW,
    output logic        IL,
    output logic [1:0]  PS
);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CLS_W-1:0] cls;
    logic [3:0]       dr, sa, sb;
    logic             unused_flags;

    // Only Z steers the sequencer; the other ALU flags belong to the datapath.
    assign unused_flags = ^{V, C, N};

    assign dr = {1'b0, IR[8:6]};
    assign sa = {1'b0, IR[5:3]};
    assign sb = {1'b0, IR[2:0]};

    opcode_decoder u_decoder (
        .opcode (IR[15:9]),
        .cls    (cls)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        DA = '0; AA = '0; BA = '0; FS = FS_MOVA;
        RW = 1'b0; MB = 1'b0; MD = 1'b0; MM = 1'b0; MW = 1'b0; IL = 1'b0;
        PS = PS_HOLD;
        case (state_q)
            INF: begin
                IL = 1'b1;
                MM = 1'b1;
                state_d = EX0;
            end
            EX0: begin
                state_d = INF;
                PS = PS_INC;
                if (cls[CLS_ALU] || cls[CLS_ADI] || cls[CLS_LD]) begin
                    DA = dr; AA = sa; BA = sb; RW = 1'b1;
                    FS = cls[CLS_ALU] ? alu_fs(IR[15:9]) : (cls[CLS_ADI] ? FS_ADD : FS_MOVA);
                    MB = cls[CLS_ADI];
                    MD = cls[CLS_LD];
                end else if (cls[CLS_ST]) begin
                    AA = sa; BA = sb; MW = 1'b1;
                end else if (cls[CLS_BRZ]) begin
                    AA = sa;
                    PS = Z ? PS_BR : PS_INC;
                end else if (cls[CLS_JMP]) begin
                    AA = sa;
                    PS = PS_JMP;
                end else if (cls[CLS_LRI]) begin
                    DA = TMP_R8; AA = sa; MD = 1'b1; RW = 1'b1;
                    PS = PS_HOLD;
                    state_d = EX1;
                end else if (cls[CLS_SRM]) begin
                    DA = TMP_R8; AA = sa; RW = 1'b1;
                    PS = PS_HOLD;
                    cnt_d = IR[2:0];
                    state_d = (IR[2:0] == 3'd0) ? EX2 : EX1;
                end
            end
            EX1: begin
                state_d = INF;
                if (cls[CLS_LRI]) begin
                    DA = dr; AA = TMP_R8; MD = 1'b1; RW = 1'b1;
                    PS = PS_INC;
                end else if (cls[CLS_SRM]) begin
                    // One shift per cycle; cnt is at least 1 here so it never wraps.
                    DA = TMP_R8; BA = TMP_R8; FS = FS_SHR; RW = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    state_d = (cnt_q == 3'd1) ? EX2 : EX1;
                end
            end
            EX2: begin
                DA = dr; AA = TMP_R8; RW = 1'b1;
                PS = PS_INC;
                state_d = INF;
            end
            default: state_d = INF;
        endcase
        if (!reset) begin
            DA = '0; AA = '0; BA = '0; FS = '0;
            RW = 1'b0; MB = 1'b0; MD = 1'b0; MM = 1'b0; MW = 1'b0; IL = 1'b0;
            PS = PS_HOLD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INF;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class through
// its cycles and compares the control word against hand-derived values.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] IR;
    logic        V, C, N, Z;
    logic [3:0]  DA, AA, BA, FS;
    logic        RW, MB, MD, MM, MW, IL;
    logic [1:0]  PS;

    int tests_run;
    int fail_count;

    localparam logic [23:0] ALL    = 24'hFFFFFF;
    localparam logic [23:0] NO_DA  = 24'h0FFFFF;
    localparam logic [23:0] BR_MSK = 24'h00008B;
    localparam logic [23:0] JM_MSK = 24'h0F008B;

    control_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .IR    (IR),
        .V     (V),
        .C     (C),
        .N     (N),
        .Z     (Z),
        .DA    (DA),
        .AA    (AA),
        .BA    (BA),
        .FS    (FS),
        .RW    (RW),
        .MB    (MB),
        .MD    (MD),
        .MM    (MM),
        .MW    (MW),
        .IL    (IL),
        .PS    (PS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [23:0] cw(input logic [3:0] da, input logic [3:0] aa,
                                       input logic [3:0] ba, input logic [3:0] fs,
                                       input logic rw, input logic mb, input logic md,
                                       input logic mm, input logic mw, input logic il,
                                       input logic [1:0] ps);
        return {da, aa, ba, fs, rw, mb, md, mm, mw, il, ps};
    endfunction

    task automatic applyStimulus(input logic [15:0] ir, input logic z, input logic other);
        IR = ir;
        Z  = z;
        V  = other;
        C  = other;
        N  = other;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] exp, input logic [23:0] mask);
        logic [23:0] obs;
        obs = {DA, AA, BA, FS, RW, MB, MD, MM, MW, IL, PS};
        tests_run++;
        assert ((obs & mask) === (exp & mask)) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs & mask, exp & mask);
        end
    endtask

    task automatic checkState(input string tag, input logic [1:0] exp_state, input logic [2:0] exp_cnt);
        logic [4:0] obs;
        obs = {dut.state_q, dut.cnt_q};
        tests_run++;
        assert (obs === {exp_state, exp_cnt}) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed state/cnt %b expected %b", tag, obs, {exp_state, exp_cnt});
        end
    endtask

    initial begin
        logic [23:0] inf_w, zero_w, shr_w;
        inf_w  = cw(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        zero_w = 24'h000000;
        shr_w  = cw(4'h8, 4'h0, 4'h8, 4'hD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        tests_run  = 0;
        fail_count = 0;

        reset = 1'b0;
        applyStimulus(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("reset_hold", zero_w, ALL);
        end
        checkState("reset_state", INF, 3'd0);
        reset = 1'b1;
        #1;
        checkOutput("first_fetch", inf_w, ALL);

        // ADD R3 <= R1 + R2
        applyStimulus(16'b0000010_011_001_010, 1'b0, 1'b1);
        step(); checkOutput("add_ex0", cw(4'h3, 4'h1, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01), ALL);
        step(); checkOutput("add_inf", inf_w, ALL);

        applyStimulus(16'b1000010_001_010_101, 1'b0, 1'b0);
        step(); checkOutput("adi_ex0", cw(4'h1, 4'h2, 4'h5, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01), ALL);
        step(); checkOutput("adi_inf", inf_w, ALL);

        applyStimulus(16'b0100000_000_011_100, 1'b1, 1'b1);
        step(); checkOutput("st_ex0", cw(4'h0, 4'h3, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01), NO_DA);
        step(); checkOutput("st_inf", inf_w, ALL);

        applyStimulus(16'b1100000_010_001_011, 1'b1, 1'b0);
        step(); checkOutput("brz_taken", cw(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10), BR_MSK);
        step(); checkOutput("brz_taken_inf", inf_w, ALL);

        applyStimulus(16'b1100000_010_001_011, 1'b0, 1'b1);
        step(); checkOutput("brz_not_taken", cw(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01), BR_MSK);
        step(); checkOutput("brz_not_taken_inf", inf_w, ALL);

        applyStimulus(16'b1110000_000_101_000, 1'b1, 1'b0);
        step(); checkOutput("jmp_ex0", cw(4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11), JM_MSK);
        step(); checkOutput("jmp_inf", inf_w, ALL);

        // LRI R5 <= M[M[R2]]
        applyStimulus(16'b0010001_101_010_000, 1'b0, 1'b0);
        step(); checkOutput("lri_ex0", cw(4'h8, 4'h2, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00), ALL);
        step(); checkOutput("lri_ex1", cw(4'h5, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01), ALL);
        step(); checkOutput("lri_inf", inf_w, ALL);

        // SRM R4 <= R6 >> 3
        applyStimulus(16'b0001101_100_110_011, 1'b1, 1'b1);
        step(); checkOutput("srm3_ex0", cw(4'h8, 4'h6, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), ALL);
        checkState("srm3_ex0_state", EX0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            step(); checkOutput("srm3_ex1", shr_w, ALL);
        end
        checkState("srm3_last_ex1", EX1, 3'd1);
        step(); checkOutput("srm3_ex2", cw(4'h4, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01), ALL);
        step(); checkOutput("srm3_inf", inf_w, ALL);

        // SRM R1 <= R7 >> 0
        applyStimulus(16'b0001101_001_111_000, 1'b0, 1'b0);
        step(); checkOutput("srm0_ex0", cw(4'h8, 4'h7, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), ALL);
        step(); checkOutput("srm0_ex2", cw(4'h1, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01), ALL);
        step(); checkOutput("srm0_inf", inf_w, ALL);

        // Abort an SRM in its second shift cycle
        applyStimulus(16'b0001101_100_110_011, 1'b0, 1'b0);
        step();
        step(); checkState("abort_first_ex1", EX1, 3'd3);
        step(); checkState("abort_second_ex1", EX1, 3'd2);
        reset = 1'b0;
        #1;
        checkOutput("abort_outputs", zero_w, ALL);
        checkState("abort_state", INF, 3'd0);
        step(); checkOutput("abort_hold", zero_w, ALL);
        reset = 1'b1;
        #1;
        checkOutput("abort_release", inf_w, ALL);
        checkState("abort_release_state", INF, 3'd0);

        applyStimulus(16'hFFFF, 1'b1, 1'b1);
        step(); checkOutput("nop_ex0", cw(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01), ALL);
        step(); checkOutput("nop_inf", inf_w, ALL);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
